// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports,
// scoreboard set request and the registered busy vector.
interface regfile_mp_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NR   = 2
);
    localparam int AW = $clog2(NREG);

    logic [NR*AW-1:0]   ra;
    logic [NR*XLEN-1:0] rd;
    logic [NR-1:0]      rbusy;
    logic               we0;
    logic [AW-1:0]      wa0;
    logic [XLEN-1:0]    wd0;
    logic               we1;
    logic [AW-1:0]      wa1;
    logic [XLEN-1:0]    wd1;
    logic               sb_set;
    logic [AW-1:0]      sb_addr;
    logic [NREG-1:0]    busy;

    modport master (
        output ra, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr,
        input  rd, rbusy, busy
    );

    modport slave (
        input  ra, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr,
        output rd, rbusy, busy
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file: NR combinational read ports, two write
// ports (port 1 wins collisions), optional write bypass and a busy scoreboard.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NR       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    regfile_mp_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_we0_eff;
    logic            w_we1_eff;
    logic            w_sb_eff;

    // Port 0 is dropped when port 1 targets the same register.
    assign w_we1_eff = bus.we1 && !((ZERO_REG != 0) && (bus.wa1 == '0));
    assign w_we0_eff = bus.we0 && !((ZERO_REG != 0) && (bus.wa0 == '0))
                       && !(bus.we1 && (bus.wa1 == bus.wa0));
    assign w_sb_eff  = bus.sb_set && !((ZERO_REG != 0) && (bus.sb_addr == '0));

    // NOTE: the storage array is in the async reset on purpose -- every
    // register must read 0 the instant reset_n falls, so it cannot map to a
    // plain RAM macro without reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we0_eff) r_mem[bus.wa0] <= bus.wd0;
            if (w_we1_eff) r_mem[bus.wa1] <= bus.wd1;
        end
    end

    // Clears first, then the set, so a newer producer keeps the register busy.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would infer a latch.
        w_busy_nxt = r_busy;
        if (bus.we0) w_busy_nxt[bus.wa0] = 1'b0;
        if (bus.we1) w_busy_nxt[bus.wa1] = 1'b0;
        if (w_sb_eff) w_busy_nxt[bus.sb_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.busy = r_busy;

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_hit0;
        logic            w_hit1;
        logic [XLEN-1:0] w_data;
        logic            w_rbusy;

        assign w_addr = bus.ra[k*AW +: AW];
        assign w_hit0 = bus.we0 && (bus.wa0 == w_addr);
        assign w_hit1 = bus.we1 && (bus.wa1 == w_addr);

        // Reset and the zero register override any bypassed write data.
        always_comb begin
            w_data  = r_mem[w_addr];
            w_rbusy = r_busy[w_addr];
            if (BYPASS != 0) begin
                if (w_hit0) w_data = bus.wd0;
                if (w_hit1) w_data = bus.wd1;
                if (w_hit0 || w_hit1) w_rbusy = 1'b0;
            end
            if ((ZERO_REG != 0) && (w_addr == '0)) w_data = '0;
            if (!reset_n) begin
                w_data  = '0;
                w_rbusy = 1'b0;
            end
        end

        assign bus.rd[k*XLEN +: XLEN] = w_data;
        assign bus.rbusy[k]           = w_rbusy;
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: a default build (bypass on), a no-bypass build and an
// NR=4 / NREG=16 build, all sharing one clock and reset.
module tb_regfile_mp_sb;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    regfile_mp_sb_if #(.XLEN(32), .NREG(32), .NR(2)) ba ();
    regfile_mp_sb_if #(.XLEN(32), .NREG(32), .NR(2)) bb ();
    regfile_mp_sb_if #(.XLEN(32), .NREG(16), .NR(4)) bc ();

    regfile_mp_sb #(.XLEN(32), .NREG(32), .NR(2), .BYPASS(1), .ZERO_REG(1))
        u_a (.clk(clk), .reset_n(reset_n), .bus(ba));
    regfile_mp_sb #(.XLEN(32), .NREG(32), .NR(2), .BYPASS(0), .ZERO_REG(1))
        u_b (.clk(clk), .reset_n(reset_n), .bus(bb));
    regfile_mp_sb #(.XLEN(32), .NREG(16), .NR(4), .BYPASS(1), .ZERO_REG(1))
        u_c (.clk(clk), .reset_n(reset_n), .bus(bc));

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        sb;
        logic [4:0]  sba;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rb;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_a(input vec_t v);
        ba.we0     = v.we0;
        ba.wa0     = v.wa0;
        ba.wd0     = v.wd0;
        ba.we1     = v.we1;
        ba.wa1     = v.wa1;
        ba.wd1     = v.wd1;
        ba.sb_set  = v.sb;
        ba.sb_addr = v.sba;
        ba.ra      = {v.ra1, v.ra0};
    endtask

    task automatic idle_b();
        bb.we0 = 1'b0; bb.wa0 = '0; bb.wd0 = '0;
        bb.we1 = 1'b0; bb.wa1 = '0; bb.wd1 = '0;
        bb.sb_set = 1'b0; bb.sb_addr = '0; bb.ra = '0;
    endtask

    task automatic idle_c();
        bc.we0 = 1'b0; bc.wa0 = '0; bc.wd0 = '0;
        bc.we1 = 1'b0; bc.wa1 = '0; bc.wd1 = '0;
        bc.sb_set = 1'b0; bc.sb_addr = '0; bc.ra = '0;
    endtask

    initial begin
        //           we0 wa0 wd0           we1 wa1 wd1           sb sba ra0 ra1  rd0           rd1           rb     busy
        vecs[0]  = '{1, 7, 32'h1234,      0, 0, 32'h0,         0, 0,  7,  5,  32'h1234,     32'h0,        2'b00, 32'h0};
        vecs[1]  = '{0, 0, 32'h0,         0, 0, 32'h0,         1, 9,  7,  9,  32'h1234,     32'h0,        2'b00, 32'h0};
        vecs[2]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  9,  7,  32'h0,        32'h1234,     2'b01, 32'h200};
        vecs[3]  = '{1, 3, 32'hAAAA,      1, 3, 32'hBBBB,      0, 0,  3,  9,  32'hBBBB,     32'h0,        2'b10, 32'h200};
        vecs[4]  = '{1, 9, 32'h99,        0, 0, 32'h0,         1, 9,  3,  9,  32'hBBBB,     32'h99,       2'b00, 32'h200};
        vecs[5]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  9,  3,  32'h99,       32'hBBBB,     2'b01, 32'h200};
        vecs[6]  = '{1, 9, 32'h100,       0, 0, 32'h0,         0, 0,  9,  0,  32'h100,      32'h0,        2'b00, 32'h200};
        vecs[7]  = '{0, 0, 32'h0,         1, 0, 32'hFFFFFFFF,  1, 0,  0,  9,  32'h0,        32'h100,      2'b00, 32'h0};
        vecs[8]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  0,  9,  32'h0,        32'h100,      2'b00, 32'h0};
        vecs[9]  = '{0, 0, 32'h0,         1, 5, 32'hDEAD,      1, 5,  5,  7,  32'hDEAD,     32'h1234,     2'b00, 32'h0};
        vecs[10] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  5,  1,  32'hDEAD,     32'h0,        2'b01, 32'h20};
        vecs[11] = '{1, 1, 32'h11,        1, 2, 32'h22,        0, 0,  2,  1,  32'h22,       32'h11,       2'b00, 32'h20};
        vecs[12] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0,  1,  2,  32'h11,       32'h22,       2'b00, 32'h20};

        apply_a('{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00, 32'h0});
        idle_b();
        idle_c();

        // Reset state.
        #1;
        check("reset_a_rd", 128'(ba.rd), 128'h0);
        check("reset_a_busy", 128'(ba.busy), 128'h0);
        check("reset_c_busy", 128'(bc.busy), 128'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven sequence on the bypass build; each row is one cycle.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            apply_a(vecs[i]);
            #1;
            check($sformatf("v%0d_rd0", i), 128'(ba.rd[31:0]), 128'(vecs[i].e_rd0));
            check($sformatf("v%0d_rd1", i), 128'(ba.rd[63:32]), 128'(vecs[i].e_rd1));
            check($sformatf("v%0d_rbusy", i), 128'(ba.rbusy), 128'(vecs[i].e_rb));
            check($sformatf("v%0d_busy", i), 128'(ba.busy), 128'(vecs[i].e_busy));
        end

        // Mid-cycle async reset with a write to x5 in flight.
        @(negedge clk);
        apply_a('{1, 5, 32'h55, 0, 0, 32'h0, 0, 0, 5, 0, 32'h0, 32'h0, 2'b00, 32'h0});
        #2;
        reset_n = 1'b0;
        #1;
        check("t1_rd0_in_reset", 128'(ba.rd[31:0]), 128'h0);
        check("t1_rbusy_in_reset", 128'(ba.rbusy), 128'h0);
        check("t1_busy_in_reset", 128'(ba.busy), 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_a('{0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 5, 7, 32'h0, 32'h0, 2'b00, 32'h0});
        @(negedge clk);
        #1;
        check("t1_x5_after", 128'(ba.rd[31:0]), 128'h0);
        check("t1_x7_after", 128'(ba.rd[63:32]), 128'h0);

        // No-bypass build: same-cycle read returns old data and old busy.
        @(negedge clk);
        bb.we0 = 1'b1; bb.wa0 = 5'd7; bb.wd0 = 32'h1111;
        bb.sb_set = 1'b1; bb.sb_addr = 5'd7;
        @(negedge clk);
        bb.sb_set = 1'b0;
        bb.wd0 = 32'h1234;
        bb.ra = {5'd0, 5'd7};
        #1;
        check("b_rd0_old", 128'(bb.rd[31:0]), 128'h1111);
        check("b_rbusy_old", 128'(bb.rbusy), 128'h1);
        @(negedge clk);
        bb.we0 = 1'b0;
        #1;
        check("b_rd0_new", 128'(bb.rd[31:0]), 128'h1234);
        check("b_rbusy_new", 128'(bb.rbusy), 128'h0);
        check("b_busy_new", 128'(bb.busy), 128'h0);

        // NR=4, NREG=16 build: write x1..x4 then read all four at once.
        @(negedge clk);
        bc.we0 = 1'b1; bc.wa0 = 4'd1; bc.wd0 = 32'd1;
        bc.we1 = 1'b1; bc.wa1 = 4'd2; bc.wd1 = 32'd2;
        @(negedge clk);
        bc.wa0 = 4'd3; bc.wd0 = 32'd3;
        bc.wa1 = 4'd4; bc.wd1 = 32'd4;
        @(negedge clk);
        bc.we0 = 1'b0;
        bc.we1 = 1'b0;
        bc.ra = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        check("c_rd_all", bc.rd, {32'd4, 32'd3, 32'd2, 32'd1});
        check("c_rbusy", 128'(bc.rbusy), 128'h0);
        bc.ra = {4'd0, 4'd1, 4'd4, 4'd3};
        #1;
        check("c_rd_mixed", bc.rd, {32'd0, 32'd1, 32'd4, 32'd3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
